// File: rtl/modular_addsub_pipe_if.sv
// Operand/result stream bundle for modular_addsub_pipe.
// slave = the adder/subtractor, master = producer plus consumer.
interface modular_addsub_pipe_if #(
   parameter int DATA_WIDTH = 256,
   parameter int TAG_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_op;
   logic [DATA_WIDTH-1:0] in_x;
   logic [DATA_WIDTH-1:0] in_y;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_z;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic                  out_err;

   modport slave (
      input  in_valid, in_op, in_x, in_y, in_tag, out_ready,
      output in_ready, out_valid, out_z, out_tag, out_err
   );

   modport master (
      output in_valid, in_op, in_x, in_y, in_tag, out_ready,
      input  in_ready, out_valid, out_z, out_tag, out_err
   );
endinterface

// File: rtl/modular_addsub_pipe.sv
// Two-stage pipelined (x+y) mod M / (x-y) mod M with valid/ready flow control.
// Optional MODADD_RANGE_CHECK_EN flags operands >= M on out_err.
module modular_addsub_pipe #(
   parameter int                    DATA_WIDTH = 256,
   parameter logic [DATA_WIDTH-1:0] M          =
      256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
   parameter int                    TAG_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   modular_addsub_pipe_if.slave     bus
);
   logic                  w_s2_adv;
   logic                  w_s1_adv;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_ge;
   logic                  w_fix;
   logic [DATA_WIDTH-1:0] w_z;

   logic                  r_s1_valid;
   logic                  r_s1_op;
   logic                  r_s1_cb;
   logic [DATA_WIDTH-1:0] r_s1_raw;
   logic [TAG_WIDTH-1:0]  r_s1_tag;

   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_s2_z;
   logic [TAG_WIDTH-1:0]  r_s2_tag;

   assign w_s2_adv    = ~r_s2_valid | bus.out_ready;
   assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
   assign bus.in_ready = w_s1_adv;

   // Bit DATA_WIDTH is the carry for add and the borrow for subtract.
   assign w_sum = bus.in_op ? ({1'b0, bus.in_x} - {1'b0, bus.in_y})
                            : ({1'b0, bus.in_x} + {1'b0, bus.in_y});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= 1'b0;
         r_s1_cb    <= 1'b0;
         r_s1_raw   <= '0;
         r_s1_tag   <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_op  <= bus.in_op;
            r_s1_cb  <= w_sum[DATA_WIDTH];
            r_s1_raw <= w_sum[DATA_WIDTH-1:0];
            r_s1_tag <= bus.in_tag;
         end
      end
   end

   assign w_ge  = (r_s1_raw >= M);
   assign w_fix = r_s1_op ? r_s1_cb : (r_s1_cb | w_ge);

   always_comb begin
      w_z = r_s1_raw;
      if (w_fix) begin
         if (r_s1_op) w_z = r_s1_raw + M;
         else         w_z = r_s1_raw - M;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_z     <= '0;
         r_s2_tag   <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_z   <= w_z;
            r_s2_tag <= r_s1_tag;
         end
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.out_z     = r_s2_z;
   assign bus.out_tag   = r_s2_tag;

`ifdef MODADD_RANGE_CHECK_EN
   logic r_s1_err;
   logic r_s2_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_err <= 1'b0;
      end else if (w_s1_adv && bus.in_valid) begin
         r_s1_err <= (bus.in_x >= M) | (bus.in_y >= M);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_err <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         r_s2_err <= r_s1_err;
      end
   end

   assign bus.out_err = r_s2_err;
`else
   assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Directed-vector bench for modular_addsub_pipe.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_modular_addsub_pipe;
   localparam logic [255:0] M =
      256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   modular_addsub_pipe_if #(.DATA_WIDTH(256), .TAG_WIDTH(8)) bus ();

   modular_addsub_pipe #(
      .DATA_WIDTH(256),
      .M         (M),
      .TAG_WIDTH (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic op,
                        input logic [255:0] x, input logic [255:0] y,
                        input logic [7:0] tag);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_tag   = tag;
   endtask

   // Single op through an empty pipe: accept, one cycle in S1, then out.
   task automatic run_op(input string name, input logic op,
                         input logic [255:0] x, input logic [255:0] y,
                         input logic [7:0] tag, input logic [255:0] ez,
                         input logic ee, input logic chk_z);
      bus.out_ready = 1'b1;
      drive(1'b1, op, x, y, tag);
      check({name, "_rdy"}, {255'd0, bus.in_ready}, 256'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, 8'h00);
      check({name, "_v0"}, {255'd0, bus.out_valid}, 256'd0);
      step();
      check({name, "_v1"}, {255'd0, bus.out_valid}, 256'd1);
      if (chk_z) check({name, "_z"}, bus.out_z, ez);
      check({name, "_tag"}, {248'd0, bus.out_tag}, {248'd0, tag});
      check({name, "_err"}, {255'd0, bus.out_err}, {255'd0, ee});
      step();
      check({name, "_drain"}, {255'd0, bus.out_valid}, 256'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 8'h00);
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
      check("rst_out_z", bus.out_z, 256'd0);
      check("rst_out_tag", {248'd0, bus.out_tag}, 256'd0);
      check("rst_out_err", {255'd0, bus.out_err}, 256'd0);
      check("rst_in_ready", {255'd0, bus.in_ready}, 256'd1);

      run_op("add_wrap", 1'b0, M - 1, 256'd1, 8'h11, 256'd0, 1'b0, 1'b1);
      run_op("add_big", 1'b0, M - 1, M - 1, 8'h12, M - 2, 1'b0, 1'b1);
      run_op("add_small", 1'b0, 256'd5, 256'd7, 8'h13, 256'd12, 1'b0, 1'b1);
      run_op("sub_borrow", 1'b1, 256'd0, 256'd1, 8'h14, M - 1, 1'b0, 1'b1);
      run_op("sub_plain", 1'b1, 256'd10, 256'd3, 8'h15, 256'd7, 1'b0, 1'b1);
      run_op("sub_zero", 1'b1, 256'd3, 256'd3, 8'h16, 256'd0, 1'b0, 1'b1);
      run_op("add_00", 1'b0, 256'd0, 256'd0, 8'h17, 256'd0, 1'b0, 1'b1);
      run_op("sub_00", 1'b1, 256'd0, 256'd0, 8'h18, 256'd0, 1'b0, 1'b1);

      // Backpressure: tags 1,2,3(,4) with out_ready low, then released.
      bus.out_ready = 1'b0;
      drive(1'b1, 1'b0, 256'd1, 256'd1, 8'd1);
      check("bp_rdy1", {255'd0, bus.in_ready}, 256'd1);
      step();
      drive(1'b1, 1'b0, 256'd2, 256'd2, 8'd2);
      check("bp_rdy2", {255'd0, bus.in_ready}, 256'd1);
      step();
      drive(1'b1, 1'b0, 256'd3, 256'd3, 8'd3);
      check("bp_full", {255'd0, bus.in_ready}, 256'd0);
      check("bp_tag_a", {248'd0, bus.out_tag}, 256'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         check("bp_hold_rdy", {255'd0, bus.in_ready}, 256'd0);
         check("bp_hold_v", {255'd0, bus.out_valid}, 256'd1);
         check("bp_hold_z", bus.out_z, 256'd2);
         check("bp_hold_tag", {248'd0, bus.out_tag}, 256'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_rdy", {255'd0, bus.in_ready}, 256'd1);
      step();
      drive(1'b1, 1'b0, 256'd4, 256'd4, 8'd4);
      check("bp_out2_v", {255'd0, bus.out_valid}, 256'd1);
      check("bp_out2_tag", {248'd0, bus.out_tag}, 256'd2);
      check("bp_out2_z", bus.out_z, 256'd4);
      check("bp_full_flow", {255'd0, bus.in_ready}, 256'd1);
      step();
      drive(1'b0, 1'b0, '0, '0, 8'h00);
      check("bp_out3_v", {255'd0, bus.out_valid}, 256'd1);
      check("bp_out3_tag", {248'd0, bus.out_tag}, 256'd3);
      check("bp_out3_z", bus.out_z, 256'd6);
      step();
      check("bp_out4_v", {255'd0, bus.out_valid}, 256'd1);
      check("bp_out4_tag", {248'd0, bus.out_tag}, 256'd4);
      check("bp_out4_z", bus.out_z, 256'd8);
      step();
      check("bp_empty", {255'd0, bus.out_valid}, 256'd0);

      // Reset with two ops in flight discards both.
      drive(1'b1, 1'b0, 256'd20, 256'd1, 8'h21);
      step();
      drive(1'b1, 1'b0, 256'd30, 256'd1, 8'h22);
      step();
      drive(1'b0, 1'b0, '0, '0, 8'h00);
      check("mid_v", {255'd0, bus.out_valid}, 256'd1);
      check("mid_z", bus.out_z, 256'd21);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_v", {255'd0, bus.out_valid}, 256'd0);
      check("mrst_z", bus.out_z, 256'd0);
      check("mrst_tag", {248'd0, bus.out_tag}, 256'd0);
      check("mrst_rdy", {255'd0, bus.in_ready}, 256'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("mrst_no_stale", {255'd0, bus.out_valid}, 256'd0);
      end

`ifdef MODADD_RANGE_CHECK_EN
      run_op("rc_bad", 1'b0, M, 256'd0, 8'h31, 256'd0, 1'b1, 1'b0);
      run_op("rc_ok", 1'b0, M - 1, 256'd0, 8'h32, M - 1, 1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/modular_addsub_pipe.md
Name: modular_addsub_pipe

Overview:
Pipelined modular adder/subtractor over a prime field with a compile-time modulus M. It computes (x+y) mod M or (x-y) mod M. It is the streaming successor of the combinational field adder. It sits between the NTT/poly-multiply datapath and its operand buffers, and uses a valid/ready handshake with backpressure, throughput 1 op/cycle and a pass-through tag.

Parameters:
DATA_WIDTH, 256, operand/result width W.
M, 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001, field modulus; requires 1 < M < 2^W.
TAG_WIDTH, 8, width of the user tag carried alongside each operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_op  input  1  0 = add, 1 = subtract (x - y)
in_x  input  DATA_WIDTH  operand x, must be < M
in_y  input  DATA_WIDTH  operand y, must be < M
in_tag  input  TAG_WIDTH  user tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_z  output  DATA_WIDTH  result in [0, M)
out_tag  output  TAG_WIDTH  tag of this result
out_err  output  1  range-error flag (only with the optional feature, else tied 0)

Behaviour:
- One clock (clk), synchronous active-high reset (rst). Everything is sampled on the rising edge of clk.
- Transfer happens when valid && ready on the same edge, on both sides.
- Two register stages, S1 and S2. S2 drives the outputs directly; there is no combinational path from in_* to out_*.
- Latency: a result appears on out_* exactly 2 cycles after acceptance when there is no backpressure.
- S1 (raw stage):
  - add: raw = x + y, kept as W+1 bits including carry.
  - sub: raw = x - y, kept as W bits plus a borrow bit.
  - S1 registers raw, carry/borrow, op and tag.
- S2 (correction stage):
  - add: if carry==1 or raw >= M, z = raw - M (mod 2^W); else z = raw.
  - sub: if borrow==1, z = raw + M (mod 2^W); else z = raw.
  - S2 registers z and tag.
- Result is always in [0, M) when both inputs are < M. Output for inputs >= M is undefined unless the optional feature is enabled.
- Flow control:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready and the stage valids.
- S2 loads from S1 when s2_adv. If s1_valid==0 at that point, s2_valid clears once the current result is consumed.
- S1 loads from the inputs when s1_adv. s1_valid <= in_valid.
- While stalled (out_valid && !out_ready), out_z, out_tag and out_err hold stable.
- At most 2 operations are in flight. Order is strictly preserved, with no reordering or dropping.
- Simultaneous accept on input and output in one cycle with both stages full: all three transfers occur and the pipeline stays full.
- Reset values: out_valid=0, out_z=0, out_tag=0, out_err=0, internal valids=0.
- in_ready = 1 in the first cycle after rst deasserts.
- Reset asserted mid-operation discards all in-flight operations; nothing is emitted for them.
- Boundary values:
  - x=y=0 add gives 0.
  - x=0, y=0 sub gives 0.
  - The carry-out case applies when M > 2^(W-1); it is handled by the carry term in the add rule.

Optional Feature:
Macro MODADD_RANGE_CHECK_EN.
- Defined: S1 additionally registers the flag (in_x >= M) | (in_y >= M). S2 drives it on out_err, aligned with its result. out_z for a flagged operation is still produced by the normal rules, with no guarantee on its value. Flow is unaffected.
- Not defined: no comparators are instantiated and out_err is constant 0.

Test Plan:
- Add wrap, out_ready=1. Send x=M-1, y=1, op=0, tag=0x11. Expect out_z=0, tag 0x11, 2 cycles after acceptance.
- Add, large operands. Send x=M-1, y=M-1, op=0. Expect out_z=M-2. Then x=5, y=7 → 12.
- Sub borrow. Send x=0, y=1, op=1 → out_z=M-1. Send x=10, y=3, op=1 → 7. Send x=3, y=3, op=1 → 0.
- Backpressure. Hold out_ready=0 and offer tags 1,2,3 on consecutive cycles with in_valid=1. Expect in_ready to fall after 2 acceptances and out_z/out_tag to stay stable. Raise out_ready. Expect tags in order 1,2,3 and one result per cycle, with no gaps while a new input is offered every cycle.
- Reset mid-flight. Accept 2 operations, then assert rst for 1 cycle. Expect out_valid=0 and outputs 0, no stale result afterwards, in_ready=1 on the next cycle.
- With MODADD_RANGE_CHECK_EN defined: send x=M, y=0 → out_err=1 with that result. Send x=M-1, y=0 → out_err=0, out_z=M-1.
